// File: rtl/ram_seq_pkg.sv
// Shared types for the RAM stage sequencer: FSM states, error codes and the
// enabled-stage search used to pick the next RAM owner.
package ram_seq_pkg;

   localparam int unsigned MAX_STAGES = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_PULSE,
      S_WAIT,
      S_NEXT,
      S_DONE,
      S_ERR
   } seq_state_t;

   localparam logic [1:0] ERR_NONE        = 2'd0;
   localparam logic [1:0] ERR_SUCCESS_LOW = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT     = 2'd2;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } next_sel_t;

   // Lowest enabled stage index strictly above cur.
   function automatic next_sel_t next_enabled(input logic [MAX_STAGES-1:0] mask,
                                              input logic [2:0]            cur);
      next_sel_t r;
      r.found = 1'b0;
      r.idx   = '0;
      for (int unsigned i = 0; i < MAX_STAGES; i++) begin
         if (!r.found && mask[i] && (i > 32'(cur))) begin
            r.found = 1'b1;
            r.idx   = 3'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_port_mux.sv
// N:1 combinational mux of client BSRAM ports; controls are gated by grant_valid,
// address/data pass through from the selected client regardless.
module ram_port_mux #(
   parameter int unsigned N  = 2,
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 32
) (
   input  logic            grant_valid,
   input  logic [2:0]      sel,
   input  logic [N-1:0]    cl_oce,
   input  logic [N-1:0]    cl_ce,
   input  logic [N-1:0]    cl_wre,
   input  logic [N*AW-1:0] cl_ad,
   input  logic [N*DW-1:0] cl_din,
   output logic            ram_oce,
   output logic            ram_ce,
   output logic            ram_wre,
   output logic [AW-1:0]   ram_ad,
   output logic [DW-1:0]   ram_din
);

   logic          sel_oce;
   logic          sel_ce;
   logic          sel_wre;
   logic [AW-1:0] sel_ad;
   logic [DW-1:0] sel_din;

   always_comb begin
      sel_oce = 1'b0;
      sel_ce  = 1'b0;
      sel_wre = 1'b0;
      sel_ad  = '0;
      sel_din = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == 3'(i)) begin
            sel_oce = cl_oce[i];
            sel_ce  = cl_ce[i];
            sel_wre = cl_wre[i];
            sel_ad  = cl_ad[i*AW +: AW];
            sel_din = cl_din[i*DW +: DW];
         end
      end
   end

   assign ram_oce = grant_valid & sel_oce;
   assign ram_ce  = grant_valid & sel_ce;
   assign ram_wre = grant_valid & sel_wre;
   assign ram_ad  = sel_ad;
   assign ram_din = sel_din;

endmodule

// File: rtl/ram_stage_sequencer.sv
// Runs a chain of stages sharing one single-port BSRAM: grants the port to one
// stage at a time, pulses its start and waits for finish/success or timeout.
module ram_stage_sequencer
   import ram_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned AW         = 11,
   parameter int unsigned DW         = 32,
   parameter int unsigned TW         = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [NUM_STAGES-1:0]    stage_en,
   input  logic [TW-1:0]            timeout_cycles,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [2:0]               err_stage,
   output logic [1:0]               err_code,
   output logic [2:0]               owner,
   output logic                     grant_valid,
   output logic [NUM_STAGES-1:0]    stage_start,
   input  logic [NUM_STAGES-1:0]    stage_finish,
   input  logic [NUM_STAGES-1:0]    stage_success,
   input  logic [NUM_STAGES-1:0]    cl_oce,
   input  logic [NUM_STAGES-1:0]    cl_ce,
   input  logic [NUM_STAGES-1:0]    cl_wre,
   input  logic [NUM_STAGES*AW-1:0] cl_ad,
   input  logic [NUM_STAGES*DW-1:0] cl_din,
   output logic                     ram_oce,
   output logic                     ram_ce,
   output logic                     ram_wre,
   output logic [AW-1:0]            ram_ad,
   output logic [DW-1:0]            ram_din
);

   seq_state_t              state_q, state_d;
   logic [NUM_STAGES-1:0]   mask_q, mask_d;
   logic [2:0]              owner_q, owner_d;
   logic [2:0]              err_stage_q, err_stage_d;
   logic [1:0]              err_code_q, err_code_d;
   logic                    error_q, error_d;
   logic [TW-1:0]           tcnt_q, tcnt_d;

   logic [MAX_STAGES-1:0]   mask_ext;
   logic [MAX_STAGES-1:0]   en_ext;
   next_sel_t               nxt_sel;
   next_sel_t               first_sel;
   logic                    own_finish;
   logic                    own_success;
   logic                    tmo_hit;
   logic                    run_gate;

   assign mask_ext  = MAX_STAGES'(mask_q);
   assign en_ext    = MAX_STAGES'(stage_en);
   assign nxt_sel   = next_enabled(mask_ext, owner_q);
   assign first_sel = next_enabled(en_ext, 3'd0);
   assign tmo_hit   = (timeout_cycles != '0) && (tcnt_q == timeout_cycles - TW'(1));

   always_comb begin
      own_finish  = 1'b0;
      own_success = 1'b0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         if (owner_q == 3'(i)) begin
            own_finish  = stage_finish[i];
            own_success = stage_success[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         owner_q     <= '0;
         err_stage_q <= '0;
         err_code_q  <= ERR_NONE;
         error_q     <= 1'b0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         owner_q     <= owner_d;
         err_stage_q <= err_stage_d;
         err_code_q  <= err_code_d;
         error_q     <= error_d;
         tcnt_q      <= tcnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      owner_d     = owner_q;
      err_stage_d = err_stage_q;
      err_code_d  = err_code_q;
      error_d     = error_q;
      tcnt_d      = tcnt_q;
      // abort outranks finish and timeout, and leaves the error record untouched
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mask_d     = stage_en;
                  error_d    = 1'b0;
                  err_code_d = ERR_NONE;
                  if (stage_en[0]) begin
                     state_d = S_GRANT;
                     owner_d = '0;
                  end else if (first_sel.found) begin
                     state_d = S_GRANT;
                     owner_d = first_sel.idx;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_GRANT: state_d = S_PULSE;
            S_PULSE: begin
               tcnt_d  = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               tcnt_d = tcnt_q + TW'(1);
               if (own_finish) begin
                  if (own_success) begin
                     state_d = S_NEXT;
                  end else begin
                     state_d     = S_ERR;
                     error_d     = 1'b1;
                     err_stage_d = owner_q;
                     err_code_d  = ERR_SUCCESS_LOW;
                  end
               end else if (tmo_hit) begin
                  state_d     = S_ERR;
                  error_d     = 1'b1;
                  err_stage_d = owner_q;
                  err_code_d  = ERR_TIMEOUT;
               end
            end
            S_NEXT: begin
               if (nxt_sel.found) begin
                  state_d = S_GRANT;
                  owner_d = nxt_sel.idx;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Port release does not wait for the edge when abort or reset is raised.
   assign run_gate    = !abort && !rst;
   assign grant_valid = (state_q inside {S_GRANT, S_PULSE, S_WAIT}) && run_gate;
   assign busy        = state_q inside {S_GRANT, S_PULSE, S_WAIT, S_NEXT};
   assign done        = (state_q == S_DONE) && !abort;
   assign error       = error_q;
   assign err_stage   = err_stage_q;
   assign err_code    = err_code_q;
   assign owner       = owner_q;

   always_comb begin
      stage_start = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         if ((state_q == S_PULSE) && (owner_q == 3'(i)) && run_gate) begin
            stage_start[i] = 1'b1;
         end
      end
   end

   ram_port_mux #(
      .N  (NUM_STAGES),
      .AW (AW),
      .DW (DW)
   ) u_mux (
      .grant_valid (grant_valid),
      .sel         (owner_q),
      .cl_oce      (cl_oce),
      .cl_ce       (cl_ce),
      .cl_wre      (cl_wre),
      .cl_ad       (cl_ad),
      .cl_din      (cl_din),
      .ram_oce     (ram_oce),
      .ram_ce      (ram_ce),
      .ram_wre     (ram_wre),
      .ram_ad      (ram_ad),
      .ram_din     (ram_din)
   );

endmodule

// File: tb/tb_ram_stage_sequencer.sv
// Scoreboard bench for ram_stage_sequencer: directed runs push expected events
// and per-cycle port expectations; a negedge monitor pops and compares.
module tb_ram_stage_sequencer;

   localparam int N  = 3;
   localparam int AW = 11;
   localparam int DW = 32;
   localparam int TW = 24;

   localparam int EV_START = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;

   typedef struct {
      int kind;
      int idx;
      int code;
      int cyc;
   } ev_t;

   typedef struct {
      int cyc;
      int gv;
      int own;
      int busy;
      int err;
      bit rstchk;
   } rec_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [N-1:0]    stage_en = '0;
   logic [TW-1:0]   timeout_cycles = '0;
   logic            busy, done, error, grant_valid;
   logic [2:0]      err_stage, owner;
   logic [1:0]      err_code;
   logic [N-1:0]    stage_start;
   logic [N-1:0]    stage_finish;
   logic [N-1:0]    stage_success;
   logic [N-1:0]    cl_oce, cl_ce, cl_wre;
   logic [N*AW-1:0] cl_ad;
   logic [N*DW-1:0] cl_din;
   logic            ram_oce, ram_ce, ram_wre;
   logic [AW-1:0]   ram_ad;
   logic [DW-1:0]   ram_din;

   int           cyc = 0;
   int           nchecks = 0;
   int           nerrors = 0;
   bit           stim_done = 1'b0;
   int           forbid_owner = -1;
   bit           forbid_all = 1'b0;
   int           dly [N];
   logic [N-1:0] succ_cfg = '1;
   logic [N-1:0] never_cfg = '0;
   int           kill_gen = 0;
   ev_t          expq [$];
   rec_t         cycq [$];

   function automatic logic [AW-1:0] ad_of(input int i);
      return AW'(32'h100 + i * 17);
   endfunction

   function automatic logic [DW-1:0] din_of(input int i);
      return 32'hA5C3_0000 + DW'(i * 3 + 1);
   endfunction

   assign cl_oce        = 3'b101;
   assign cl_ce         = 3'b111;
   assign cl_wre        = 3'b010;
   assign stage_success = succ_cfg;
   for (genvar g = 0; g < N; g++) begin : g_cl
      assign cl_ad[g*AW +: AW]  = ad_of(g);
      assign cl_din[g*DW +: DW] = din_of(g);
   end

   ram_stage_sequencer #(
      .NUM_STAGES (N),
      .AW         (AW),
      .DW         (DW),
      .TW         (TW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .stage_en       (stage_en),
      .timeout_cycles (timeout_cycles),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .err_stage      (err_stage),
      .err_code       (err_code),
      .owner          (owner),
      .grant_valid    (grant_valid),
      .stage_start    (stage_start),
      .stage_finish   (stage_finish),
      .stage_success  (stage_success),
      .cl_oce         (cl_oce),
      .cl_ce          (cl_ce),
      .cl_wre         (cl_wre),
      .cl_ad          (cl_ad),
      .cl_din         (cl_din),
      .ram_oce        (ram_oce),
      .ram_ce         (ram_ce),
      .ram_wre        (ram_wre),
      .ram_ad         (ram_ad),
      .ram_din        (ram_din)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stage model: finish is held high exactly dly[i] cycles after the start pulse.
   initial begin
      int cd [N];
      int seen_kill;
      seen_kill = 0;
      for (int i = 0; i < N; i++) cd[i] = 0;
      stage_finish = '0;
      forever begin
         @(posedge clk);
         #1;
         if (kill_gen != seen_kill) begin
            for (int i = 0; i < N; i++) cd[i] = 0;
            seen_kill = kill_gen;
         end
         stage_finish = '0;
         for (int i = 0; i < N; i++) begin
            if (cd[i] > 0) begin
               cd[i] = cd[i] - 1;
               if (cd[i] == 0) stage_finish[i] = 1'b1;
            end
         end
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (stage_start[i] && !never_cfg[i]) cd[i] = dly[i];
      end
   end

   task automatic push_ev(input int k, input int idx, input int code, input int c);
      ev_t e;
      e.kind = k; e.idx = idx; e.code = code; e.cyc = c;
      expq.push_back(e);
   endtask

   task automatic push_rec(input int c, input int gv, input int own, input int bsy,
                           input int err, input bit rchk);
      rec_t r;
      r.cyc = c; r.gv = gv; r.own = own; r.busy = bsy; r.err = err; r.rstchk = rchk;
      cycq.push_back(r);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_run(input logic [N-1:0] m, input logic ab, output int s);
      @(posedge clk);
      #1;
      stage_en = m;
      start    = 1'b1;
      abort    = ab;
      s        = cyc;
      @(posedge clk);
      #1;
      start    = 1'b0;
      abort    = 1'b0;
      stage_en = '1;
   endtask

   task automatic handle_event(input int k, input int idx, input int code);
      ev_t e;
      nchecks++;
      if (expq.size() == 0) begin
         nerrors++;
         $display("FAIL event: got kind=%0d idx=%0d code=%0d at cycle %0d, expected no event",
                  k, idx, code, cyc);
      end else begin
         e = expq.pop_front();
         if (e.kind != k || e.idx != idx || e.code != code || e.cyc != cyc) begin
            nerrors++;
            $display("FAIL event: got kind=%0d idx=%0d code=%0d cycle=%0d, expected kind=%0d idx=%0d code=%0d cycle=%0d",
                     k, idx, code, cyc, e.kind, e.idx, e.code, e.cyc);
         end
      end
   endtask

   task automatic check_rec(input rec_t r);
      bit bad;
      bad = 1'b0;
      nchecks++;
      if (r.rstchk) begin
         bad = busy || done || error || grant_valid || (err_stage != 3'd0) ||
               (err_code != 2'd0) || (owner != 3'd0) || (stage_start != '0);
      end else begin
         if (r.gv >= 0 && grant_valid != r.gv[0]) bad = 1'b1;
         if (r.busy >= 0 && busy != r.busy[0]) bad = 1'b1;
         if (r.err >= 0 && error != r.err[0]) bad = 1'b1;
         if (r.gv == 1) begin
            if (owner != 3'(r.own) || ram_ce != cl_ce[r.own] || ram_oce != cl_oce[r.own] ||
                ram_wre != cl_wre[r.own] || ram_ad != ad_of(r.own) || ram_din != din_of(r.own))
               bad = 1'b1;
         end else if (r.gv == 0) begin
            if (ram_ce || ram_oce || ram_wre) bad = 1'b1;
         end
      end
      if (bad) begin
         nerrors++;
         $display("FAIL port_cycle_%0d: got gv=%0b owner=%0d busy=%0b done=%0b error=%0b err_stage=%0d err_code=%0d ce/oce/wre=%0b%0b%0b ad=%h din=%h; expected gv=%0d owner=%0d busy=%0d error=%0d reset_state=%0b",
                  r.cyc, grant_valid, owner, busy, done, error, err_stage, err_code,
                  ram_ce, ram_oce, ram_wre, ram_ad, ram_din, r.gv, r.own, r.busy, r.err, r.rstchk);
      end
   endtask

   // Monitor / checker
   initial begin
      bit   err_prev;
      rec_t r;
      err_prev = 1'b0;
      while (!stim_done) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (stage_start[i]) handle_event(EV_START, i, 0);
         if (done) handle_event(EV_DONE, 0, 0);
         if (error && !err_prev) handle_event(EV_ERR, int'(err_stage), int'(err_code));
         err_prev = error;
         while (cycq.size() > 0 && cycq[0].cyc <= cyc) begin
            r = cycq.pop_front();
            check_rec(r);
         end
         if (forbid_all || forbid_owner >= 0) begin
            nchecks++;
            if (grant_valid && (forbid_all || int'(owner) == forbid_owner)) begin
               nerrors++;
               $display("FAIL forbidden_grant: got grant_valid=1 owner=%0d at cycle %0d, expected no grant (forbid_all=%0b forbid_owner=%0d)",
                        owner, cyc, forbid_all, forbid_owner);
            end
         end
      end
      nchecks++;
      if (expq.size() != 0) begin
         nerrors++;
         $display("FAIL missing_events: got %0d unconsumed, expected 0 (next kind=%0d idx=%0d cycle=%0d)",
                  expq.size(), expq[0].kind, expq[0].idx, expq[0].cyc);
      end
      nchecks++;
      if (cycq.size() != 0) begin
         nerrors++;
         $display("FAIL missing_port_checks: got %0d unchecked, expected 0", cycq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   // Stimulus
   initial begin
      int s;
      for (int i = 0; i < N; i++) dly[i] = 10;
      push_rec(2, -1, 0, -1, -1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Two stages back to back; a second start mid-run must be ignored
      dly[0] = 100; dly[1] = 50;
      start_run(3'b011, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_ev(EV_START, 1, 0, s + 105);
      push_ev(EV_DONE,  0, 0, s + 157);
      push_rec(s + 1,   1, 0, 1, 0, 1'b0);
      push_rec(s + 50,  1, 0, 1, -1, 1'b0);
      push_rec(s + 102, 1, 0, 1, -1, 1'b0);
      push_rec(s + 103, 0, 0, 1, -1, 1'b0);
      push_rec(s + 104, 1, 1, 1, -1, 1'b0);
      push_rec(s + 130, 1, 1, 1, -1, 1'b0);
      push_rec(s + 157, 0, 0, 0, 0, 1'b0);
      push_rec(s + 158, 0, 0, 0, 0, 1'b0);
      wait_until(s + 50);
      start = 1'b1;
      wait_until(s + 51);
      start = 1'b0;
      wait_until(s + 165);

      // Mask 101: stage 1 is skipped entirely
      dly[0] = 20; dly[2] = 30;
      forbid_owner = 1;
      start_run(3'b101, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_ev(EV_START, 2, 0, s + 25);
      push_ev(EV_DONE,  0, 0, s + 57);
      push_rec(s + 23, 0, 0, 1, -1, 1'b0);
      push_rec(s + 24, 1, 2, 1, -1, 1'b0);
      push_rec(s + 55, 1, 2, 1, -1, 1'b0);
      wait_until(s + 62);
      forbid_owner = -1;

      // Empty mask: straight to DONE, no grant
      forbid_all = 1'b1;
      start_run(3'b000, 1'b0, s);
      push_ev(EV_DONE, 0, 0, s + 1);
      push_rec(s + 1, 0, 0, 0, 0, 1'b0);
      push_rec(s + 2, 0, 0, 0, 0, 1'b0);
      wait_until(s + 6);
      forbid_all = 1'b0;

      // Timeout of 10: expiry on the 10th WAIT cycle, ERR the cycle after
      timeout_cycles = 24'd10;
      never_cfg = 3'b001;
      start_run(3'b001, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_ev(EV_ERR,   0, 2, s + 13);
      push_rec(s + 12, 1, 0, 1, 0, 1'b0);
      push_rec(s + 13, 0, 0, 0, 1, 1'b0);
      push_rec(s + 16, 0, 0, 0, 1, 1'b0);
      wait_until(s + 18);
      never_cfg = '0;
      kill_gen++;

      // Finish lands on the expiry cycle: finish wins
      dly[0] = 10;
      start_run(3'b001, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_ev(EV_DONE,  0, 0, s + 14);
      push_rec(s + 1,  1, 0, 1, 0, 1'b0);
      push_rec(s + 12, 1, 0, 1, 0, 1'b0);
      push_rec(s + 13, 0, 0, 1, 0, 1'b0);
      wait_until(s + 18);

      // Stage 1 reports success low
      timeout_cycles = '0;
      dly[0] = 10; dly[1] = 10;
      succ_cfg = 3'b101;
      start_run(3'b011, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_ev(EV_START, 1, 0, s + 15);
      push_ev(EV_ERR,   1, 1, s + 26);
      push_rec(s + 26, 0, 0, 0, 1, 1'b0);
      push_rec(s + 30, 0, 0, 0, 1, 1'b0);
      wait_until(s + 32);
      succ_cfg = '1;

      // Abort while stage 0 waits; the new start also clears the error
      dly[0] = 100;
      start_run(3'b011, 1'b0, s);
      push_ev(EV_START, 0, 0, s + 2);
      push_rec(s + 1,  1, 0, 1, 0, 1'b0);
      push_rec(s + 20, 0, 0, -1, 0, 1'b0);
      push_rec(s + 21, 0, 0, 0, 0, 1'b0);
      push_rec(s + 40, 0, 0, 0, 0, 1'b0);
      wait_until(s + 20);
      abort = 1'b1;
      wait_until(s + 21);
      abort = 1'b0;
      kill_gen++;
      wait_until(s + 45);

      // start+abort in IDLE takes the start; then reset mid-run on stage 1
      dly[1] = 100;
      start_run(3'b010, 1'b1, s);
      push_ev(EV_START, 1, 0, s + 2);
      push_rec(s + 5,  1, 1, 1, 0, 1'b0);
      push_rec(s + 10, 0, 0, -1, -1, 1'b0);
      push_rec(s + 11, -1, 0, -1, -1, 1'b1);
      push_rec(s + 15, -1, 0, -1, -1, 1'b1);
      wait_until(s + 10);
      rst = 1'b1;
      wait_until(s + 11);
      rst = 1'b0;
      kill_gen++;
      wait_until(s + 20);

      stim_done = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
